// File: rtl/event_timestamp_fifo.sv
// Purpose: timestamps rising edges of the async event_a input with live NTP time and queues them in a FWFT FIFO.
// Latency: 2-FF sync + delay FF to detect; the entry shows in count/notEmpty/head on the clk after the detect clk.
// Backpressure: none upstream; a full FIFO drops the event (sticky overflow, saturating lostCount) unless a pop lands on the same clk.
//
// Ports:
//   clk, rst                    system clock, synchronous active-high reset
//   event_a                     asynchronous event input
//   seconds, fraction           live NTP time, same clock domain
//   secondsValid                NTP "seconds valid" status, captured with each stamp
//   readStrobe, clearStrobe     pop head entry / clear overflow and lostCount
//   headSeconds/Fraction/Valid  head entry (qualify with notEmpty)
//   notEmpty, count             FIFO occupancy
//   overflow, lostCount         dropped-event status
module event_timestamp_fifo #(
    parameter int    DEPTH_L2       = 4,
    parameter int    HOLDOFF_CLOCKS = 1000,
    parameter string DEBUG          = "false"
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                event_a,
    input  logic [31:0]         seconds,
    input  logic [31:0]         fraction,
    input  logic                secondsValid,
    input  logic                readStrobe,
    input  logic                clearStrobe,
    output logic [31:0]         headSeconds,
    output logic [31:0]         headFraction,
    output logic                headValid,
    output logic                notEmpty,
    output logic [DEPTH_L2:0]   count,
    output logic                overflow,
    output logic [15:0]         lostCount
);

    localparam int Depth = 1 << DEPTH_L2;
    localparam int PtrW  = DEPTH_L2 + 1;
    localparam int HoldW = (HOLDOFF_CLOCKS > 1) ? $clog2(HOLDOFF_CLOCKS) : 1;

    typedef struct packed {
        logic        valid;
        logic [31:0] sec;
        logic [31:0] frac;
    } stamp_t;

    // ---------------- edge detection ----------------
    (* ASYNC_REG = "TRUE" *) logic syncA;
    (* ASYNC_REG = "TRUE" *) logic syncB;
    logic syncDly;
    logic edgeDet;

    always_ff @(posedge clk) begin
        if (rst) begin
            syncA   <= 1'b0;
            syncB   <= 1'b0;
            syncDly <= 1'b0;
        end else begin
            syncA   <= event_a;
            syncB   <= syncA;
            syncDly <= syncB;
        end
    end

    assign edgeDet = syncB & ~syncDly;

    // ---------------- holdoff ----------------
    logic [HoldW-1:0] holdoff;
    logic             holdoffDone;
    logic             acceptEdge;
    logic             acceptTap;

    assign holdoffDone = (holdoff == '0);
    assign acceptEdge  = edgeDet && holdoffDone;

    // Optional probe point on the accepted-edge path for on-chip debug.
    if (DEBUG == "true") begin : gDebugTap
        (* mark_debug = "true" *) logic acceptProbe;
        assign acceptProbe = acceptEdge;
        assign acceptTap   = acceptProbe;
    end else begin : gNoDebugTap
        assign acceptTap = acceptEdge;
    end

    // Every accepted edge re-arms the holdoff, including one dropped by a full FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            holdoff <= '0;
        end else if (acceptTap) begin
            holdoff <= HoldW'(HOLDOFF_CLOCKS - 1);
        end else if (!holdoffDone) begin
            holdoff <= holdoff - HoldW'(1);
        end
    end

    // ---------------- FIFO ----------------
    stamp_t            mem [Depth];
    stamp_t            headReg;
    stamp_t            wrData;
    logic [PtrW-1:0]   wrPtr;
    logic [PtrW-1:0]   rdPtr;
    logic [PtrW-1:0]   nextRd;
    logic              full;
    logic              pop;
    logic              push;
    logic              drop;

    assign wrData   = '{valid: secondsValid, sec: seconds, frac: fraction};
    assign notEmpty = (wrPtr != rdPtr);
    assign full     = (wrPtr[PtrW-1] != rdPtr[PtrW-1]) &&
                      (wrPtr[PtrW-2:0] == rdPtr[PtrW-2:0]);
    assign count    = wrPtr - rdPtr;
    assign pop      = readStrobe && notEmpty;
    // A pop on the same clk frees the slot, so a full FIFO still accepts.
    assign push     = acceptTap && (!full || pop);
    assign drop     = acceptTap && full && !pop;
    assign nextRd   = pop ? rdPtr + PtrW'(1) : rdPtr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr[PtrW-2:0]] <= wrData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            headReg   <= '0;
            overflow  <= 1'b0;
            lostCount <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PtrW'(1);
            end
            if (pop) begin
                rdPtr <= nextRd;
            end

            // Head register: bypass the write data when the new entry becomes
            // the head; otherwise follow the read pointer. It only moves when
            // a valid entry lands at the head, so it never loads unwritten RAM.
            if (push && (nextRd == wrPtr)) begin
                headReg <= wrData;
            end else if (pop && (nextRd != wrPtr)) begin
                headReg <= mem[nextRd[PtrW-2:0]];
            end

            // A drop coinciding with a clear wins over the clear.
            if (clearStrobe) begin
                overflow  <= drop;
                lostCount <= drop ? 16'd1 : 16'd0;
            end else if (drop) begin
                overflow <= 1'b1;
                if (lostCount != 16'hFFFF) begin
                    lostCount <= lostCount + 16'd1;
                end
            end
        end
    end

    assign headSeconds  = headReg.sec;
    assign headFraction = headReg.frac;
    assign headValid    = headReg.valid;

endmodule

// File: tb/tb_event_timestamp_fifo.sv
// Bench for event_timestamp_fifo: directed scenarios plus a randomized phase,
// all checked against a queue-based reference model kept in this file.
module tb_event_timestamp_fifo;

    localparam int HOLD = 1000;
    localparam int CAP  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        event_a;
    logic [31:0] seconds;
    logic [31:0] fraction;
    logic        secondsValid;
    logic        readStrobe;
    logic        clearStrobe;
    logic [31:0] headSeconds;
    logic [31:0] headFraction;
    logic        headValid;
    logic        notEmpty;
    logic [4:0]  count;
    logic        overflow;
    logic [15:0] lostCount;

    event_timestamp_fifo #(
        .DEPTH_L2      (4),
        .HOLDOFF_CLOCKS(HOLD),
        .DEBUG         ("false")
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .event_a     (event_a),
        .seconds     (seconds),
        .fraction    (fraction),
        .secondsValid(secondsValid),
        .readStrobe  (readStrobe),
        .clearStrobe (clearStrobe),
        .headSeconds (headSeconds),
        .headFraction(headFraction),
        .headValid   (headValid),
        .notEmpty    (notEmpty),
        .count       (count),
        .overflow    (overflow),
        .lostCount   (lostCount)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        bit        v;
        bit [31:0] s;
        bit [31:0] f;
    } ent_t;

    ent_t q[$];
    bit   mOvf;
    int   mLost;
    bit   haveAccept;
    int   lastAccept;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int lastRise = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // An edge is accepted if no edge was accepted in the previous HOLD clocks.
    task automatic modelEdge(int rise, bit v, bit [31:0] s, bit [31:0] f);
        ent_t e;
        if (!haveAccept || (rise - lastAccept) >= HOLD) begin
            haveAccept = 1'b1;
            lastAccept = rise;
            if (q.size() < CAP) begin
                e.v = v; e.s = s; e.f = f;
                q.push_back(e);
            end else begin
                mOvf = 1'b1;
                if (mLost < 65535) mLost++;
            end
        end
    endtask

    task automatic modelReset();
        q.delete();
        mOvf = 1'b0;
        mLost = 0;
        haveAccept = 1'b0;
    endtask

    task automatic checkAll(string tag);
        chk({tag, ".count"},    64'(count),     64'(q.size()));
        chk({tag, ".notEmpty"}, 64'(notEmpty),  64'(q.size() != 0));
        chk({tag, ".overflow"}, 64'(overflow),  64'(mOvf));
        chk({tag, ".lost"},     64'(lostCount), 64'(mLost));
        if (q.size() != 0) begin
            chk({tag, ".headSec"},  64'(headSeconds),  64'(q[0].s));
            chk({tag, ".headFrac"}, 64'(headFraction), 64'(q[0].f));
            chk({tag, ".headVal"},  64'(headValid),    64'(q[0].v));
        end
    endtask

    // Timestamp inputs change together with the rising edge and stay put until
    // the next event, so the captured stamp does not depend on pipeline depth.
    task automatic sendEvent(int width, bit v, bit [31:0] s, bit [31:0] f);
        secondsValid = v;
        seconds      = s;
        fraction     = f;
        event_a      = 1'b1;
        lastRise     = cyc;
        modelEdge(cyc, v, s, f);
        repeat (width) tick();
        event_a = 1'b0;
    endtask

    task automatic waitUntil(int t);
        while (cyc < t) tick();
    endtask

    task automatic doRead();
        readStrobe = 1'b1;
        tick();
        readStrobe = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        modelReset();
    endtask

    task automatic drainCheck(string tag);
        while (q.size() != 0) begin
            checkAll(tag);
            doRead();
        end
        checkAll(tag);
    endtask

    initial begin
        rst = 1'b1; event_a = 1'b0; seconds = '0; fraction = '0;
        secondsValid = 1'b0; readStrobe = 1'b0; clearStrobe = 1'b0;
        modelReset();
        repeat (3) tick();

        // Reset state
        chk("rst.count",    64'(count),        64'd0);
        chk("rst.notEmpty", 64'(notEmpty),     64'd0);
        chk("rst.overflow", 64'(overflow),     64'd0);
        chk("rst.lost",     64'(lostCount),    64'd0);
        chk("rst.headSec",  64'(headSeconds),  64'd0);
        chk("rst.headFrac", 64'(headFraction), 64'd0);
        chk("rst.headVal",  64'(headValid),    64'd0);
        rst = 1'b0;
        repeat (5) tick();

        // 1: single event, 50-clk pulse
        secondsValid = 1'b1; seconds = 32'h1234_5678; fraction = 32'h8000_0000;
        event_a = 1'b1; lastRise = cyc;
        modelEdge(cyc, 1'b1, 32'h1234_5678, 32'h8000_0000);
        tick();
        chk("t1.early_count", 64'(count), 64'd0);
        repeat (3) tick();
        checkAll("t1");
        repeat (46) tick();
        event_a = 1'b0;
        doRead();
        repeat (2) tick();
        checkAll("t1.popped");

        // 2: holdoff
        doReset();
        repeat (20) tick();
        sendEvent(5, 1'b0, 32'hA, 32'hA0);
        waitUntil(lastRise + 10);
        sendEvent(5, 1'b1, 32'hB, 32'hB0);
        repeat (10) tick();
        checkAll("t2.bounce");
        waitUntil(lastRise - 10 + 1200);
        sendEvent(5, 1'b1, 32'hC, 32'hC0);
        repeat (10) tick();
        checkAll("t2.third");
        waitUntil(lastRise + 999);
        sendEvent(5, 1'b1, 32'hD, 32'hD0);
        repeat (10) tick();
        checkAll("t2.at999");
        waitUntil(lastRise + 1001);
        sendEvent(5, 1'b0, 32'hE, 32'hE0);
        waitUntil(lastRise + 1000);
        sendEvent(5, 1'b1, 32'hF, 32'hF0);
        repeat (10) tick();
        checkAll("t2.at1000");

        // 3: 17 events, no reads
        doReset();
        repeat (5) tick();
        for (int i = 0; i < 17; i++) begin
            if (i != 0) waitUntil(lastRise + HOLD);
            sendEvent(20, 1'(i % 2), 32'h100 + 32'(i), 32'hF000_0000 + 32'(i));
        end
        repeat (5) tick();
        checkAll("t3.full");

        // 4: full FIFO, pop on the same clk as the push
        waitUntil(lastRise + HOLD);
        secondsValid = 1'b1; seconds = 32'hCAFE_0001; fraction = 32'hBEEF_0001;
        event_a = 1'b1; lastRise = cyc;
        tick();
        tick();
        readStrobe = 1'b1;
        tick();
        readStrobe = 1'b0;
        void'(q.pop_front());
        modelEdge(lastRise, 1'b1, 32'hCAFE_0001, 32'hBEEF_0001);
        repeat (10) tick();
        event_a = 1'b0;
        checkAll("t4.pushpop");
        drainCheck("t4.drain");

        // 5: read while empty, clear, clear on the same clk as a drop
        doRead();
        repeat (2) tick();
        checkAll("t5.emptyRead");
        waitUntil(lastRise + HOLD);
        sendEvent(10, 1'b0, 32'h5555_0000, 32'h0000_5555);
        repeat (5) tick();
        checkAll("t5.afterEmptyRead");
        clearStrobe = 1'b1;
        tick();
        clearStrobe = 1'b0;
        mOvf = 1'b0; mLost = 0;
        checkAll("t5.clear");
        for (int i = 0; i < 17; i++) begin
            waitUntil(lastRise + HOLD);
            sendEvent(10, 1'b1, 32'h600 + 32'(i), 32'h700 + 32'(i));
        end
        repeat (5) tick();
        checkAll("t5.twoDrops");
        waitUntil(lastRise + HOLD);
        secondsValid = 1'b1; seconds = 32'h77; fraction = 32'h88;
        event_a = 1'b1; lastRise = cyc;
        tick();
        tick();
        clearStrobe = 1'b1;
        tick();
        clearStrobe = 1'b0;
        mOvf = 1'b0; mLost = 0;
        modelEdge(lastRise, 1'b1, 32'h77, 32'h88);
        repeat (10) tick();
        event_a = 1'b0;
        checkAll("t5.clearDrop");

        // 6: reset mid-operation with holdoff running
        for (int i = 0; i < 12; i++) doRead();
        waitUntil(lastRise + HOLD);
        sendEvent(10, 1'b1, 32'h9999, 32'h1111);
        repeat (5) tick();
        checkAll("t6.five");
        doReset();
        checkAll("t6.reset");
        sendEvent(10, 1'b0, 32'h4242, 32'h2424);
        repeat (5) tick();
        checkAll("t6.afterReset");

        // Randomized phase
        for (int i = 0; i < 20; i++) begin
            int gap;
            case ($urandom_range(0, 5))
                0:       gap = 500;
                1:       gap = 999;
                2:       gap = 1000;
                3:       gap = 1001;
                default: gap = int'($urandom_range(1000, 1400));
            endcase
            waitUntil(lastRise + gap);
            sendEvent(int'($urandom_range(5, 40)), 1'($urandom_range(0, 1)),
                      $urandom, $urandom);
            repeat (8) tick();
            checkAll("rnd.push");
            for (int r = int'($urandom_range(0, 3)); r > 0; r--) begin
                doRead();
            end
            if ($urandom_range(0, 7) == 0) begin
                clearStrobe = 1'b1;
                tick();
                clearStrobe = 1'b0;
                mOvf = 1'b0; mLost = 0;
            end
            tick();
            checkAll("rnd.read");
        end
        drainCheck("rnd.drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
